// File: rtl/pwm_medidor_pkg.sv
// Shared definitions for the PWM measurement block (and its pwm_basico
// counterpart): default resolution, FSM state encoding and counter width.
package pwm_medidor_pkg;

  localparam int R_DEF    = 8;
  localparam int SYNC_DEF = 2;

  typedef enum logic [1:0] {
    S_ESPERA = 2'd0,  // no rising edge seen yet, nothing being measured
    S_ALTO   = 2'd1,  // counting the high phase
    S_BAJO   = 2'd2   // counting the low phase
  } estado_t;

  // Counter width: must hold the timeout value 2**(R+1).
  function automatic int cw_de(input int r);
    return r + 2;
  endfunction

endpackage

// File: rtl/pwm_medidor_if.sv
// Bus between the PWM line / measurement consumer and pwm_medidor.
//   pwm_in    : asynchronous PWM line
//   ciclo     : measured high count, saturated to 2**R-1
//   periodo   : high+low count of the last full period
//   valido    : one-cycle pulse when ciclo/periodo/estancado update
//   estancado : line stuck (no edge for TIMEOUT clocks)
// master = the measurer, slave = whoever drives the line and reads results.
interface pwm_medidor_if import pwm_medidor_pkg::*; #(parameter int R = R_DEF);

  localparam int CW = cw_de(R);

  logic          pwm_in;
  logic [R-1:0]  ciclo;
  logic [CW-1:0] periodo;
  logic          valido;
  logic          estancado;

  modport master (input pwm_in, output ciclo, periodo, valido, estancado);
  modport slave  (output pwm_in, input ciclo, periodo, valido, estancado);

endinterface

// File: rtl/pwm_medidor_sync_flanco.sv
// Synchroniser and edge detector for the incoming PWM line.
//   clk, reset : system clock, synchronous active-high reset
//   pwm_in     : asynchronous input
//   s          : synchronised level, aligned with sube/baja
//   sube, baja : registered one-cycle rising / falling edge flags
module pwm_medidor_sync_flanco #(
  parameter int SYNC = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic pwm_in,
  output logic s,
  output logic sube,
  output logic baja
);

  logic [SYNC-1:0] cadena;
  logic            s_d;

  // Edge flags are registered; s is the delayed level so that in any cycle
  // s is the level that sube/baja describe the transition into.
  always_ff @(posedge clk) begin
    if (reset) begin
      cadena <= '0;
      s_d    <= 1'b0;
      sube   <= 1'b0;
      baja   <= 1'b0;
    end else begin
      cadena <= {cadena[SYNC-2:0], pwm_in};
      s_d    <= cadena[SYNC-1];
      sube   <= cadena[SYNC-1] & ~s_d;
      baja   <= ~cadena[SYNC-1] & s_d;
    end
  end

  assign s = s_d;

endmodule

// File: rtl/pwm_medidor.sv
// PWM measurer: recovers duty (high count) and period length of an incoming
// PWM waveform and flags a stuck line.
//   clk, reset : system clock, synchronous active-high reset
//   bus        : pwm_medidor_if master (pwm_in in; ciclo, periodo, valido,
//                estancado out)
module pwm_medidor import pwm_medidor_pkg::*; #(
  parameter int R       = R_DEF,
  parameter int SYNC    = SYNC_DEF,
  parameter int TIMEOUT = 2**(R+1)
) (
  input  logic           clk,
  input  logic           reset,
  pwm_medidor_if.master  bus
);

  localparam int            CW    = cw_de(R);
  localparam logic [CW-1:0] T_ULT = CW'(TIMEOUT - 1);
  localparam logic [CW-1:0] T_FIN = CW'(TIMEOUT);
  localparam logic [CW-1:0] MAXC  = CW'(2**R - 1);

  logic          s, sube, baja;
  estado_t       estado;
  logic [CW-1:0] hcnt, lcnt, idle;
  logic          flanco, tmo;

  pwm_medidor_sync_flanco #(.SYNC(SYNC)) u_sync (
    .clk    (clk),
    .reset  (reset),
    .pwm_in (bus.pwm_in),
    .s      (s),
    .sube   (sube),
    .baja   (baja)
  );

  // An edge in the same cycle always beats the timeout.
  assign flanco = sube | baja;
  assign tmo    = (idle == T_ULT) && !flanco;

  always_ff @(posedge clk) begin
    if (reset) begin
      estado        <= S_ESPERA;
      hcnt          <= '0;
      lcnt          <= '0;
      idle          <= '0;
      bus.ciclo     <= '0;
      bus.periodo   <= '0;
      bus.valido    <= 1'b0;
      bus.estancado <= 1'b0;
    end else begin
      bus.valido <= 1'b0;
      // Idle counter parks at TIMEOUT so a long stuck line hits T_ULT once.
      if (flanco)            idle <= '0;
      else if (idle != T_FIN) idle <= idle + 1'b1;

      if (tmo) begin
        estado <= S_ESPERA;
        // Only the first timeout after a good publish is reported.
        if (!bus.estancado) begin
          bus.ciclo     <= {R{s}};
          bus.periodo   <= '0;
          bus.estancado <= 1'b1;
          bus.valido    <= 1'b1;
        end
      end else begin
        case (estado)
          S_ESPERA: if (sube) begin
            hcnt   <= CW'(1);
            lcnt   <= '0;
            estado <= S_ALTO;
          end
          S_ALTO: if (baja) begin
            lcnt   <= CW'(1);
            estado <= S_BAJO;
          end else begin
            hcnt <= hcnt + 1'b1;
          end
          S_BAJO: if (sube) begin
            bus.ciclo     <= (hcnt > MAXC) ? {R{1'b1}} : hcnt[R-1:0];
            bus.periodo   <= hcnt + lcnt;
            bus.estancado <= 1'b0;
            bus.valido    <= 1'b1;
            hcnt          <= CW'(1);
            lcnt          <= '0;
            estado        <= S_ALTO;
          end else begin
            lcnt <= lcnt + 1'b1;
          end
          default: estado <= S_ESPERA;
        endcase
      end
    end
  end

endmodule
